// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: optional inversion, synchroniser, stability
// counter, then edge pulses, long-press level and an optional auto-repeat pulse train.
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 50,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] rpt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT_CYCLES - 1);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   cand;
    logic [SW-1:0]          stable_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [RW-1:0]          rep_cnt;
    logic                   clean_q, rise_q, fall_q, held_q, rpt_q;
    logic                   clean_next, held_next;

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state of clean and held are needed so edge pulses and hold clearing
    // line up with the very edge where clean itself changes.
    always_comb begin
      clean_next = clean_q;
      if ((s == cand) && (stable_cnt == STABLE_LAST))
        clean_next = cand;
      held_next = clean_q & clean_next & (hold_cnt >= HOLD_LAST);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q     <= '0;
        cand       <= 1'b0;
        stable_cnt <= '0;
        hold_cnt   <= '0;
        rep_cnt    <= '0;
        clean_q    <= 1'b0;
        rise_q     <= 1'b0;
        fall_q     <= 1'b0;
        held_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[ch] ^ ACTIVE_LOW};

        if (s != cand) begin
          cand       <= s;
          stable_cnt <= '0;
        end else if (stable_cnt != STABLE_LAST) begin
          stable_cnt <= stable_cnt + 1'b1;
        end

        clean_q <= clean_next;
        rise_q  <= clean_next & ~clean_q;
        fall_q  <= ~clean_next & clean_q;

        // Hold count only runs across consecutive cycles of clean=1, so both the
        // rising and the falling edge of clean restart it from zero.
        if (clean_q && clean_next) begin
          if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
          hold_cnt <= '0;
        end
        held_q <= held_next;

        if (!held_next || !repeat_en[ch]) begin
          rpt_q   <= 1'b0;
          rep_cnt <= '0;
        end else if (!held_q) begin
          rpt_q   <= 1'b1;
          rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
          rpt_q   <= 1'b1;
          rep_cnt <= '0;
        end else begin
          rpt_q   <= 1'b0;
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end

    assign clean[ch] = clean_q;
    assign rise[ch]  = rise_q;
    assign fall[ch]  = fall_q;
    assign held[ch]  = held_q;
    assign rpt[ch]   = rpt_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: an active-high and an active-low instance
// with short counts, expected values written out per edge.
module tb_debounce_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_al;
  logic [3:0] noisy, repeat_en, noisy_al, repeat_en_al;
  logic [3:0] clean, rise, fall, held, rpt;
  logic [3:0] clean_al, rise_al, fall_al, held_al, rpt_al;

  int checkCount = 0;
  int passCount  = 0;

  debounce_multi #(
    .CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
    .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .noisy(noisy), .repeat_en(repeat_en),
    .clean(clean), .rise(rise), .fall(fall), .held(held), .rpt(rpt)
  );

  debounce_multi #(
    .CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
    .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst_al), .noisy(noisy_al), .repeat_en(repeat_en_al),
    .clean(clean_al), .rise(rise_al), .fall(fall_al), .held(held_al), .rpt(rpt_al)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] n, input logic [3:0] r);
    noisy     = n;
    repeat_en = r;
  endtask

  // The reset edge becomes edge 0; stimulus set afterwards is first sampled at edge 1.
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(4'h0, 4'h0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] bounce;
    bounce       = 12'b0111_0011_0011;
    rst          = 1'b1;
    rst_al       = 1'b1;
    noisy_al     = 4'hF;
    repeat_en_al = 4'h0;
    applyStimulus(4'hF, 4'h0);

    // Reset with all inputs active, then release
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rst_outs@%0d", i), {clean, rise, fall, held, rpt}, 20'h0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("t1_clean@%0d", k), clean, (k >= 7) ? 4'hF : 4'h0);
      checkOutput($sformatf("t1_rise@%0d", k), rise, (k == 7) ? 4'hF : 4'h0);
      checkOutput($sformatf("t1_fall@%0d", k), fall, 4'h0);
    end

    // Clean press and release on channel 0
    resetDut();
    noisy[0] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      checkOutput($sformatf("t2_clean@%0d", k), clean, (k >= 7 && k <= 36) ? 4'h1 : 4'h0);
      checkOutput($sformatf("t2_rise@%0d", k), rise, (k == 7) ? 4'h1 : 4'h0);
      checkOutput($sformatf("t2_fall@%0d", k), fall, (k == 37) ? 4'h1 : 4'h0);
      checkOutput($sformatf("t2_held@%0d", k), held, (k >= 17 && k <= 36) ? 4'h1 : 4'h0);
      checkOutput($sformatf("t2_rpt@%0d", k), rpt, 4'h0);
      if (k == 30) noisy[0] = 1'b0;
    end

    // Bounce on channel 1 never long enough to register
    resetDut();
    noisy[1] = bounce[0];
    for (int k = 1; k <= 25; k++) begin
      tick();
      checkOutput($sformatf("t3_clean@%0d", k), clean, 4'h0);
      checkOutput($sformatf("t3_rise@%0d", k), rise, 4'h0);
      checkOutput($sformatf("t3_fall@%0d", k), fall, 4'h0);
      noisy[1] = (k < 12) ? bounce[k] : 1'b0;
    end

    // Hold with auto-repeat on channel 2
    resetDut();
    applyStimulus(4'h4, 4'h4);
    for (int k = 1; k <= 42; k++) begin
      tick();
      checkOutput($sformatf("t4_clean@%0d", k), clean, (k >= 7 && k <= 36) ? 4'h4 : 4'h0);
      checkOutput($sformatf("t4_rise@%0d", k), rise, (k == 7) ? 4'h4 : 4'h0);
      checkOutput($sformatf("t4_fall@%0d", k), fall, (k == 37) ? 4'h4 : 4'h0);
      checkOutput($sformatf("t4_held@%0d", k), held, (k >= 17 && k <= 36) ? 4'h4 : 4'h0);
      checkOutput($sformatf("t4_rpt@%0d", k), rpt,
                  (k >= 17 && k <= 36 && (k - 17) % 3 == 0) ? 4'h4 : 4'h0);
      if (k == 30) noisy[2] = 1'b0;
    end

    // Repeat enabled late on channel 3
    resetDut();
    applyStimulus(4'h8, 4'h0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      checkOutput($sformatf("t5_held@%0d", k), held, (k >= 17) ? 4'h8 : 4'h0);
      checkOutput($sformatf("t5_rpt@%0d", k), rpt,
                  (k >= 23 && (k - 23) % 3 == 0) ? 4'h8 : 4'h0);
      if (k == 20) repeat_en[3] = 1'b1;
    end

    // Active-low instance with a reset pulse in the middle of a press
    tick();
    rst_al   = 1'b0;
    noisy_al = 4'h0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k <= 15) begin
        checkOutput($sformatf("t6_clean@%0d", k), clean_al, (k >= 7) ? 4'hF : 4'h0);
        checkOutput($sformatf("t6_rise@%0d", k), rise_al, (k == 7) ? 4'hF : 4'h0);
      end else if (k == 16) begin
        checkOutput("t6_rst_outs@16", {clean_al, rise_al, fall_al, held_al, rpt_al}, 20'h0);
      end else begin
        checkOutput($sformatf("t6_clean@%0d", k), clean_al, (k >= 23) ? 4'hF : 4'h0);
        checkOutput($sformatf("t6_rise@%0d", k), rise_al, (k == 23) ? 4'hF : 4'h0);
        checkOutput($sformatf("t6_fall@%0d", k), fall_al, 4'h0);
      end
      if (k == 15) rst_al = 1'b1;
      if (k == 16) rst_al = 1'b0;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
